// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding, fetch
// constants and the little-endian byte-lane helpers.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_F2   = 3'd3,
        ST_F3   = 3'd4,
        ST_EXEC = 3'd5,
        ST_DROP = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam int unsigned TIMEOUT_DEF   = 64;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Byte lane fetched in each fetch state; lane k lands in bits [8k+7:8k].
    function automatic logic [1:0] fetch_lane(input state_e s);
        logic [1:0] lane;
        case (s)
            ST_F1:   lane = 2'd1;
            ST_F2:   lane = 2'd2;
            ST_F3:   lane = 2'd3;
            default: lane = 2'd0;
        endcase
        return lane;
    endfunction

    function automatic logic [31:0] insert_lane(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetch/execute controller: byte-serial instruction fetch, decoder run/ok
// handshake, PC ownership, shared memory-port arbitration and a watchdog.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic [31:0] instr,
    output logic        run,
    input  logic        dec_ok,
    input  logic        dec_intr,
    input  logic        dec_pc_wren,
    input  logic [31:0] dec_pc_wdata,
    output logic [31:0] PC_rdata,
    input  logic [31:0] dec_mem_raddr,
    output logic [31:0] MMemory_raddr,
    input  logic [7:0]  MMemory_rdata,
    output logic        busy,
    output logic        halted,
    output logic        timeout_err,
    output logic [31:0] retired,
    output logic [2:0]  dbg_state_o
);

    // Handshake: run=1 holds instr stable until the decoder answers with
    // dec_ok; run then drops for at least one DROP cycle so ok can clear.

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q,   state_d;
    logic [31:0]       pc_q,      pc_d;
    logic [31:0]       instr_q,   instr_d;
    logic              run_q,     run_d;
    logic [31:0]       retired_q, retired_d;
    logic              halted_q,  halted_d;
    logic              terr_q,    terr_d;
    logic [WD_W-1:0]   wdog_q,    wdog_d;
    logic              taken_q,   taken_d;
    logic [31:0]       tgt_q,     tgt_d;

    logic [1:0]        lane;
    logic [31:0]       fetch_word;
    logic [31:0]       branch_tgt;
    logic              taken_now;

    assign lane       = fetch_lane(state_q);
    assign fetch_word = insert_lane(instr_q, lane, MMemory_rdata);
    // A PC write in the same cycle as dec_ok overrides any earlier one.
    assign branch_tgt = dec_pc_wren ? dec_pc_wdata : tgt_q;
    assign taken_now  = taken_q | dec_pc_wren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            run_q     <= 1'b0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            terr_q    <= 1'b0;
            wdog_q    <= '0;
            taken_q   <= 1'b0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            run_q     <= run_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            terr_q    <= terr_d;
            wdog_q    <= wdog_d;
            taken_q   <= taken_d;
            tgt_q     <= tgt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        run_d     = run_q;
        retired_d = retired_q;
        halted_d  = halted_q;
        terr_d    = terr_q;
        wdog_d    = wdog_q;
        taken_d   = taken_q;
        tgt_d     = tgt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_F0;
            end
            ST_F0: begin
                instr_d = fetch_word;
                state_d = ST_F1;
            end
            ST_F1: begin
                instr_d = fetch_word;
                state_d = ST_F2;
            end
            ST_F2: begin
                instr_d = fetch_word;
                state_d = ST_F3;
            end
            ST_F3: begin
                instr_d = fetch_word;
                wdog_d  = '0;
                taken_d = 1'b0;
                if (fetch_word == HALT_WORD) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    run_d   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (dec_pc_wren) begin
                    tgt_d   = dec_pc_wdata;
                    taken_d = 1'b1;
                end
                if (dec_ok) begin
                    run_d     = 1'b0;
                    pc_d      = taken_now ? branch_tgt : pc_q + PC_INC;
                    retired_d = retired_q + 32'd1;
                    if (dec_intr) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        state_d  = ST_DROP;
                    end
                end else if (wdog_q == WD_LAST) begin
                    run_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_DROP: begin
                taken_d = 1'b0;
                wdog_d  = '0;
                state_d = stop ? ST_IDLE : ST_F0;
            end
            ST_HALT: begin
                if (start) begin
                    halted_d = 1'b0;
                    terr_d   = 1'b0;
                    state_d  = ST_F0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        MMemory_raddr = pc_q;
        case (state_q)
            ST_F0, ST_F1, ST_F2, ST_F3: MMemory_raddr = pc_q + {30'd0, lane};
            ST_EXEC:                    MMemory_raddr = dec_mem_raddr;
            default:                    MMemory_raddr = pc_q;
        endcase
    end

    assign instr       = instr_q;
    assign run         = run_q;
    assign PC_rdata    = pc_q;
    assign retired     = retired_q;
    assign halted      = halted_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign dbg_state_o = state_q;

endmodule
